// File: rtl/rgb_led_driver.sv
// rgb_led_driver: checks colour code stepping from the lighting controller
// and drives three glitch-free PWM LED outputs at a latched duty.
module rgb_led_driver #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          colour,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                seq_err,
    output logic [7:0]          change_count
);

    logic [2:0]          col_q;
    logic [2:0]          disp;
    logic [PWM_BITS-1:0] duty_l;
    logic [PWM_BITS-1:0] cnt;

    logic cur_ok;
    logic hold;
    logic step;
    logic wrap;
    logic counted;
    logic legal;
    logic period_end;
    logic on;

    // 000 and 111 are never legal, not even as a repeated (held) code
    always_comb begin
        cur_ok     = (colour != 3'd0) && (colour != 3'd7);
        hold       = cur_ok && (colour == col_q);
        step       = (col_q >= 3'd1) && (col_q <= 3'd5) &&
                     (colour == col_q + 3'd1);
        wrap       = (col_q == 3'd6) && (colour == 3'd1);
        counted    = step || wrap;
        legal      = hold || counted;
        period_end = &cnt;
        on         = cnt < duty_l;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= 3'b001;
            disp         <= 3'b001;
            duty_l       <= '0;
            cnt          <= '0;
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
            seq_err      <= 1'b0;
            change_count <= 8'd0;
        end else begin
            col_q <= colour;
            cnt   <= cnt + 1'b1;
            if (!legal)
                seq_err <= 1'b1;
            if (counted && change_count != 8'hff)
                change_count <= change_count + 8'd1;
            // latch only at period end so a period is never cut short
            if (period_end) begin
                disp   <= col_q;
                duty_l <= duty;
            end
            led_r <= disp[0] && on;
            led_g <= disp[1] && on;
            led_b <= disp[2] && on;
        end
    end

endmodule

// File: tb/tb_rgb_led_driver.sv
// Directed self-checking bench for rgb_led_driver, PWM_BITS = 4.
// Time base: k counts rising edges since reset release; cnt == k % 16.
module tb_rgb_led_driver;

    localparam int PB = 4;
    localparam int P  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    colour;
    logic [PB-1:0] duty;
    logic          led_r;
    logic          led_g;
    logic          led_b;
    logic          seq_err;
    logic [7:0]    change_count;

    int k;
    int npass;
    int ntot;
    int hr;
    int hg;
    int hb;
    int first_r;

    rgb_led_driver #(.PWM_BITS(PB)) dut (
        .clk(clk),
        .rst(rst),
        .colour(colour),
        .duty(duty),
        .led_r(led_r),
        .led_g(led_g),
        .led_b(led_b),
        .seq_err(seq_err),
        .change_count(change_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] nxt(input logic [2:0] c);
        return (c == 3'd6) ? 3'd1 : c + 3'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(input int ph);
        while (k % P != ph) tick();
    endtask

    task automatic measure();
        hr = 0; hg = 0; hb = 0; first_r = 0;
        for (int i = 1; i <= P; i++) begin
            tick();
            hr += int'(led_r);
            hg += int'(led_g);
            hb += int'(led_b);
            if (led_r && first_r == 0) first_r = i;
        end
    endtask

    task automatic measure_period();
        align(0);
        measure();
    endtask

    task automatic do_reset(input logic [2:0] c, input logic [PB-1:0] d);
        rst = 1'b1;
        colour = c;
        duty = d;
        tick();
        tick();
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        do_reset(3'd1, 4'd8);
        ntot++;
        if ({led_r, led_g, led_b} !== 3'b000)
            $display("FAIL reset_leds got %b want 000", {led_r, led_g, led_b});
        else npass++;
        ntot++;
        if (seq_err !== 1'b0)
            $display("FAIL reset_seq_err got %b want 0", seq_err);
        else npass++;
        ntot++;
        if (change_count !== 8'd0)
            $display("FAIL reset_count got %0d want 0", change_count);
        else npass++;
        measure();
        ntot++;
        if (hr + hg + hb != 0)
            $display("FAIL reset_first_period got %0d/%0d/%0d want 0/0/0", hr, hg, hb);
        else npass++;
        measure();
        ntot++;
        if (hr != 8 || hg != 0 || hb != 0 || first_r != 1)
            $display("FAIL reset_second_period got r%0d g%0d b%0d first%0d want r8 g0 b0 first1",
                     hr, hg, hb, first_r);
        else npass++;
        ntot++;
        if (seq_err !== 1'b0)
            $display("FAIL reset_seq_err_hold got %b want 0", seq_err);
        else npass++;
    endtask

    task automatic test_legal_cycle();
        logic [2:0] seq [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
        foreach (seq[i]) begin
            colour = seq[i];
            run(20);
        end
        ntot++;
        if (seq_err !== 1'b0 || change_count !== 8'd7)
            $display("FAIL legal_cycle got err%b cnt%0d want err0 cnt7", seq_err, change_count);
        else npass++;
        align(0);
        colour = 3'd3;
        measure();
        ntot++;
        if (hr != 0 || hg != 8 || hb != 0)
            $display("FAIL disp_old got r%0d g%0d b%0d want r0 g8 b0", hr, hg, hb);
        else npass++;
        measure();
        ntot++;
        if (hr != 8 || hg != 8 || hb != 0 || first_r != 1)
            $display("FAIL disp_new got r%0d g%0d b%0d first%0d want r8 g8 b0 first1",
                     hr, hg, hb, first_r);
        else npass++;
    endtask

    task automatic test_period_edge_change();
        align(15);
        colour = 3'd4;
        tick();
        measure();
        ntot++;
        if (hr != 8 || hg != 8 || hb != 0)
            $display("FAIL edge_old got r%0d g%0d b%0d want r8 g8 b0", hr, hg, hb);
        else npass++;
        measure();
        ntot++;
        if (hr != 0 || hg != 0 || hb != 8)
            $display("FAIL edge_new got r%0d g%0d b%0d want r0 g0 b8", hr, hg, hb);
        else npass++;
        ntot++;
        if (change_count !== 8'd9)
            $display("FAIL edge_count got %0d want 9", change_count);
        else npass++;
    endtask

    task automatic test_illegal();
        colour = 3'd5; tick();
        colour = 3'd6; tick();
        colour = 3'd1; tick();
        ntot++;
        if (seq_err !== 1'b0 || change_count !== 8'd12)
            $display("FAIL pre_illegal got err%b cnt%0d want err0 cnt12", seq_err, change_count);
        else npass++;
        colour = 3'd3;
        tick();
        ntot++;
        if (seq_err !== 1'b1 || change_count !== 8'd12)
            $display("FAIL illegal_jump got err%b cnt%0d want err1 cnt12", seq_err, change_count);
        else npass++;
        colour = 3'd7;
        run(18);
        measure_period();
        ntot++;
        if (hr != 8 || hg != 8 || hb != 8)
            $display("FAIL white got r%0d g%0d b%0d want r8 g8 b8", hr, hg, hb);
        else npass++;
        ntot++;
        if (seq_err !== 1'b1 || change_count !== 8'd12)
            $display("FAIL sticky got err%b cnt%0d want err1 cnt12", seq_err, change_count);
        else npass++;
    endtask

    task automatic test_duty();
        int tot;
        do_reset(3'd1, 4'd0);
        run(18);
        tot = 0;
        for (int p = 0; p < 3; p++) begin
            measure_period();
            tot += hr + hg + hb;
        end
        ntot++;
        if (tot != 0)
            $display("FAIL duty_zero got %0d want 0", tot);
        else npass++;
        colour = 3'd6;
        duty = 4'd15;
        run(18);
        measure_period();
        ntot++;
        if (hr != 0 || hg != 15 || hb != 15)
            $display("FAIL duty_max got r%0d g%0d b%0d want r0 g15 b15", hr, hg, hb);
        else npass++;
        align(0);
        hg = 0;
        for (int i = 1; i <= P; i++) begin
            tick();
            hg += int'(led_g);
            if (i == 5) duty = 4'd4;
        end
        ntot++;
        if (hg != 15)
            $display("FAIL duty_mid_ignored got %0d want 15", hg);
        else npass++;
        measure();
        ntot++;
        if (hg != 4 || hb != 4 || hr != 0)
            $display("FAIL duty_next got r%0d g%0d b%0d want r0 g4 b4", hr, hg, hb);
        else npass++;
    endtask

    task automatic test_saturation();
        logic [2:0] c;
        do_reset(3'd1, 4'd8);
        c = 3'd1;
        for (int i = 0; i < 300; i++) begin
            c = nxt(c);
            colour = c;
            tick();
        end
        ntot++;
        if (change_count !== 8'd255 || seq_err !== 1'b0)
            $display("FAIL sat got cnt%0d err%b want cnt255 err0", change_count, seq_err);
        else npass++;
        run(5);
        c = nxt(c);
        colour = c;
        tick();
        ntot++;
        if (change_count !== 8'd255 || seq_err !== 1'b0)
            $display("FAIL sat_hold got cnt%0d err%b want cnt255 err0", change_count, seq_err);
        else npass++;
        colour = 3'd0;
        tick();
        ntot++;
        if (change_count !== 8'd255 || seq_err !== 1'b1)
            $display("FAIL sat_illegal got cnt%0d err%b want cnt255 err1", change_count, seq_err);
        else npass++;
    endtask

    task automatic test_reset_mid();
        logic [2:0] c;
        do_reset(3'd1, 4'd15);
        c = 3'd1;
        for (int i = 0; i < 40; i++) begin
            c = nxt(c);
            colour = c;
            tick();
        end
        colour = 3'd7;
        tick();
        ntot++;
        if (change_count !== 8'd40 || seq_err !== 1'b1)
            $display("FAIL mid_pre got cnt%0d err%b want cnt40 err1", change_count, seq_err);
        else npass++;
        run(18);
        align(9);
        ntot++;
        if ({led_r, led_g, led_b} !== 3'b111)
            $display("FAIL mid_leds_on got %b want 111", {led_r, led_g, led_b});
        else npass++;
        rst = 1'b1;
        colour = 3'd1;
        duty = 4'd8;
        tick();
        rst = 1'b0;
        k = 0;
        ntot++;
        if ({led_r, led_g, led_b} !== 3'b000 || seq_err !== 1'b0 || change_count !== 8'd0)
            $display("FAIL mid_reset got leds%b err%b cnt%0d want leds000 err0 cnt0",
                     {led_r, led_g, led_b}, seq_err, change_count);
        else npass++;
        measure();
        ntot++;
        if (hr + hg + hb != 0)
            $display("FAIL mid_first_period got %0d want 0", hr + hg + hb);
        else npass++;
        measure();
        ntot++;
        if (hr != 8 || first_r != 1 || hg != 0 || hb != 0)
            $display("FAIL mid_restart got r%0d first%0d g%0d b%0d want r8 first1 g0 b0",
                     hr, first_r, hg, hb);
        else npass++;
    endtask

    initial begin
        k = 0;
        npass = 0;
        ntot = 0;
        rst = 1'b1;
        colour = 3'd1;
        duty = '0;
        test_reset();
        test_legal_cycle();
        test_period_edge_change();
        test_illegal();
        test_duty();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
